// File: rtl/mbc_bus_pkg.sv
// Shared types and constants for the cartridge-bus initiator and its MBC1 shadow.
package mbc_bus_pkg;

   localparam int PHASE_W = 4;
   typedef logic [PHASE_W-1:0] phase_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   // External RAM window: the only range that asserts nCS.
   localparam logic [15:0] RAM_WIN_LO = 16'hA000;
   localparam logic [15:0] RAM_WIN_HI = 16'hBFFF;

   // MBC1 register windows; writes below 0x8000 land in a bank register.
   localparam logic [15:0] MBC1_ROM_LO_BASE  = 16'h2000;
   localparam logic [15:0] MBC1_BANK_HI_BASE = 16'h4000;
   localparam logic [15:0] MBC1_MODE_BASE    = 16'h6000;
   localparam logic [15:0] MBC1_REG_HI       = 16'h7FFF;
   localparam logic [3:0]  RAM_EN_KEY        = 4'hA;

   typedef enum logic [1:0] {
      REG_RAM_EN,
      REG_ROM_LO,
      REG_BANK_HI,
      REG_MODE
   } mbc1_reg_t;

   function automatic logic in_ram_window(input logic [15:0] addr);
      return (addr >= RAM_WIN_LO) && (addr <= RAM_WIN_HI);
   endfunction

   function automatic logic mbc1_reg_hit(input logic [15:0] addr);
      return addr <= MBC1_REG_HI;
   endfunction

   function automatic mbc1_reg_t mbc1_reg_sel(input logic [15:0] addr);
      if (addr < MBC1_ROM_LO_BASE)       return REG_RAM_EN;
      else if (addr < MBC1_BANK_HI_BASE) return REG_ROM_LO;
      else if (addr < MBC1_MODE_BASE)    return REG_BANK_HI;
      else                               return REG_MODE;
   endfunction

endpackage

// File: rtl/mbc_bus_master_if.sv
// Request/response channel between a host sequencer (master) and mbc_bus_master (slave).
interface mbc_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mbc1_shadow_regs.sv
// Write-snooping copy of the MBC1 bank registers, updated from completed bus writes.
module mbc1_shadow_regs
   import mbc_bus_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_we,
   input  logic [15:0] i_addr,
   input  logic [4:0]  i_wdata,
   output logic        o_ram_en,
   output logic [6:0]  o_rom_bank,
   output logic [1:0]  o_ram_bank,
   output logic        o_mode
);

   logic       r_ram_en;
   logic [4:0] r_rom_lo;
   logic [1:0] r_bank_hi;
   logic       r_mode;
   logic       w_hit;
   mbc1_reg_t  w_sel;

   always_comb begin
      w_hit = mbc1_reg_hit(i_addr);
      w_sel = mbc1_reg_sel(i_addr);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ram_en  <= 1'b0;
         r_rom_lo  <= 5'd1;
         r_bank_hi <= 2'd0;
         r_mode    <= 1'b0;
      end else if (i_we && w_hit) begin
         case (w_sel)
            REG_RAM_EN:  r_ram_en  <= (i_wdata[3:0] == RAM_EN_KEY);
            // Bank 0 is unreachable through the low register; MBC1 substitutes 1.
            REG_ROM_LO:  r_rom_lo  <= (i_wdata == 5'd0) ? 5'd1 : i_wdata;
            REG_BANK_HI: r_bank_hi <= i_wdata[1:0];
            REG_MODE:    r_mode    <= i_wdata[0];
            default:     ;
         endcase
      end
   end

   assign o_ram_en   = r_ram_en;
   assign o_rom_bank = {r_bank_hi, r_rom_lo};
   assign o_ram_bank = r_bank_hi;
   assign o_mode     = r_mode;

endmodule

// File: rtl/mbc_bus_master.sv
// Game Boy cartridge-bus initiator: one read or write at a time with programmable setup/strobe/hold.
// Define MBC1_SHADOW_EN to add the MBC1 register shadow outputs (o_shadow_*).
module mbc_bus_master
   import mbc_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   mbc_bus_master_if.slave io_req,
   output logic [15:0]     o_cart_a,
   output logic [7:0]      o_cart_d_out,
   output logic            o_cart_d_oe,
   input  logic [7:0]      i_cart_d_in,
   output logic            o_cart_nrd,
   output logic            o_cart_nwr,
   output logic            o_cart_ncs
`ifdef MBC1_SHADOW_EN
   ,
   output logic            o_shadow_ram_en,
   output logic [6:0]      o_shadow_rom_bank,
   output logic [1:0]      o_shadow_ram_bank,
   output logic            o_shadow_mode
`endif
);

   localparam phase_t SETUP_LD  = phase_t'(SETUP_CYC - 1);
   localparam phase_t STROBE_LD = phase_t'(STROBE_CYC - 1);
   localparam phase_t HOLD_LD   = phase_t'(HOLD_CYC - 1);

   state_t      r_state,     w_state_nxt;
   phase_t      r_phase,     w_phase_nxt;
   logic        r_write,     w_write_nxt;
   logic [15:0] r_cart_a,    w_cart_a_nxt;
   logic [7:0]  r_d_out,     w_d_out_nxt;
   logic        r_d_oe,      w_d_oe_nxt;
   logic        r_nrd,       w_nrd_nxt;
   logic        r_nwr,       w_nwr_nxt;
   logic        r_ncs,       w_ncs_nxt;
   logic        r_rsp_valid, w_rsp_valid_nxt;
   logic [7:0]  r_rsp_rdata, w_rsp_rdata_nxt;
   logic        w_accept;
   logic        w_phase_last;

   // Every cart_* register is loaded with the value for the state being entered,
   // so the pins change on the same edge as the FSM and never glitch.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that skips
      // an assignment would otherwise infer a latch.
      w_state_nxt     = r_state;
      w_phase_nxt     = r_phase;
      w_write_nxt     = r_write;
      w_cart_a_nxt    = r_cart_a;
      w_d_out_nxt     = r_d_out;
      w_d_oe_nxt      = r_d_oe;
      w_nrd_nxt       = r_nrd;
      w_nwr_nxt       = r_nwr;
      w_ncs_nxt       = r_ncs;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_accept        = io_req.req_valid && (r_state == ST_IDLE);
      w_phase_last    = (r_phase == '0);

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt  = ST_SETUP;
               w_phase_nxt  = SETUP_LD;
               w_write_nxt  = io_req.req_write;
               w_cart_a_nxt = io_req.req_addr;
               w_ncs_nxt    = !in_ram_window(io_req.req_addr);
               w_d_oe_nxt   = io_req.req_write;
               if (io_req.req_write) w_d_out_nxt = io_req.req_wdata;
            end
         end
         ST_SETUP: begin
            if (w_phase_last) begin
               w_state_nxt = ST_STROBE;
               w_phase_nxt = STROBE_LD;
               w_nrd_nxt   = r_write;
               w_nwr_nxt   = !r_write;
            end else begin
               w_phase_nxt = r_phase - 1'b1;
            end
         end
         ST_STROBE: begin
            if (w_phase_last) begin
               w_state_nxt = ST_HOLD;
               w_phase_nxt = HOLD_LD;
               w_nrd_nxt   = 1'b1;
               w_nwr_nxt   = 1'b1;
               if (!r_write) w_rsp_rdata_nxt = i_cart_d_in;
            end else begin
               w_phase_nxt = r_phase - 1'b1;
            end
         end
         ST_HOLD: begin
            if (w_phase_last) begin
               w_state_nxt     = ST_IDLE;
               w_phase_nxt     = '0;
               w_ncs_nxt       = 1'b1;
               w_d_oe_nxt      = 1'b0;
               w_rsp_valid_nxt = 1'b1;
            end else begin
               w_phase_nxt = r_phase - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_write     <= 1'b0;
         r_cart_a    <= '0;
         r_d_out     <= '0;
         r_d_oe      <= 1'b0;
         r_nrd       <= 1'b1;
         r_nwr       <= 1'b1;
         r_ncs       <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_phase     <= w_phase_nxt;
         r_write     <= w_write_nxt;
         r_cart_a    <= w_cart_a_nxt;
         r_d_out     <= w_d_out_nxt;
         r_d_oe      <= w_d_oe_nxt;
         r_nrd       <= w_nrd_nxt;
         r_nwr       <= w_nwr_nxt;
         r_ncs       <= w_ncs_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
      end
   end

   assign io_req.req_ready = (r_state == ST_IDLE);
   assign io_req.rsp_valid = r_rsp_valid;
   assign io_req.rsp_rdata = r_rsp_rdata;
   assign o_cart_a         = r_cart_a;
   assign o_cart_d_out     = r_d_out;
   assign o_cart_d_oe      = r_d_oe;
   assign o_cart_nrd       = r_nrd;
   assign o_cart_nwr       = r_nwr;
   assign o_cart_ncs       = r_ncs;

`ifdef MBC1_SHADOW_EN
   logic w_shadow_we;

   // The register is committed on the final strobe cycle, as the cartridge latches it.
   assign w_shadow_we = (r_state == ST_STROBE) && w_phase_last && r_write;

   mbc1_shadow_regs u_shadow (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_we       (w_shadow_we),
      .i_addr     (r_cart_a),
      .i_wdata    (r_d_out[4:0]),
      .o_ram_en   (o_shadow_ram_en),
      .o_rom_bank (o_shadow_rom_bank),
      .o_ram_bank (o_shadow_ram_bank),
      .o_mode     (o_shadow_mode)
   );
`endif

endmodule

// File: tb/tb_mbc_bus_master.sv
// Scoreboard bench for mbc_bus_master: default timing on u_dut0, 1/1/1 timing on u_dut1.
`timescale 1ns/1ps
module tb_mbc_bus_master;

   typedef struct {
      logic       wr;
      logic [7:0] rdata;
      int         lat;
      int         rd_lo;
      int         wr_lo;
      int         first_lo;
      int         ncs_lo;
   } exp_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [7:0] d_in  = 8'h00;
   int         cyc   = 0;
   int         checks   = 0;
   int         failures = 0;
   exp_t       exp_q[$];
   int         acc_log[$];
   logic [7:0] model_rdata = 8'h00;

   mbc_bus_master_if bus0 ();
   mbc_bus_master_if bus1 ();

   logic [15:0] a0, a1;
   logic [7:0]  dout0, dout1;
   logic        doe0, doe1, nrd0, nrd1, nwr0, nwr1, ncs0, ncs1;
`ifdef MBC1_SHADOW_EN
   logic       sh_ram_en0, sh_mode0, sh_ram_en1, sh_mode1;
   logic [6:0] sh_rom0, sh_rom1;
   logic [1:0] sh_ram0, sh_ram1;
`endif

   mbc_bus_master u_dut0 (
      .i_clk(clk), .i_rst(rst), .io_req(bus0),
      .o_cart_a(a0), .o_cart_d_out(dout0), .o_cart_d_oe(doe0), .i_cart_d_in(d_in),
      .o_cart_nrd(nrd0), .o_cart_nwr(nwr0), .o_cart_ncs(ncs0)
`ifdef MBC1_SHADOW_EN
      , .o_shadow_ram_en(sh_ram_en0), .o_shadow_rom_bank(sh_rom0),
      .o_shadow_ram_bank(sh_ram0), .o_shadow_mode(sh_mode0)
`endif
   );

   mbc_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .io_req(bus1),
      .o_cart_a(a1), .o_cart_d_out(dout1), .o_cart_d_oe(doe1), .i_cart_d_in(d_in),
      .o_cart_nrd(nrd1), .o_cart_nwr(nwr1), .o_cart_ncs(ncs1)
`ifdef MBC1_SHADOW_EN
      , .o_shadow_ram_en(sh_ram_en1), .o_shadow_rom_bank(sh_rom1),
      .o_shadow_ram_bank(sh_ram1), .o_shadow_mode(sh_mode1)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected response is queued at issue time; the monitor below consumes it.
   task automatic send(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                       input bit hold);
      exp_t e;
      int   n;
      if (!wr) model_rdata = d_in;
      e.wr       = wr;
      e.rdata    = model_rdata;
      e.lat      = 8;
      e.rd_lo    = wr ? 0 : 4;
      e.wr_lo    = wr ? 4 : 0;
      e.first_lo = 3;
      e.ncs_lo   = (addr >= 16'hA000 && addr <= 16'hBFFF) ? 7 : 0;
      exp_q.push_back(e);
      bus0.req_valid = 1'b1;
      bus0.req_write = wr;
      bus0.req_addr  = addr;
      bus0.req_wdata = wdata;
      n = 0;
      while (!bus0.req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus0.req_ready) check("accept_timeout", 32'(bus0.req_ready), 32'd1);
      @(posedge clk); #1;
      if (!hold) bus0.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: per-transaction pin statistics, compared when rsp_valid appears.
   bit   mon_busy = 1'b0;
   int   mon_acc, mon_rd_lo, mon_wr_lo, mon_first, mon_ncs_lo, mon_rdy, mon_both;
   exp_t mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_busy = 1'b0;
         end else begin
            if (bus0.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 32'(bus0.rsp_valid), 32'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("latency",      cyc - mon_acc, mon_e.lat);
                  check("rsp_rdata",    32'(bus0.rsp_rdata), 32'(mon_e.rdata));
                  check("nrd_low",      mon_rd_lo, mon_e.rd_lo);
                  check("nwr_low",      mon_wr_lo, mon_e.wr_lo);
                  check("strobe_start", mon_first, mon_e.first_lo);
                  check("ncs_low",      mon_ncs_lo, mon_e.ncs_lo);
                  check("busy_ready",   mon_rdy, 0);
                  check("strobe_both",  mon_both, 0);
               end
               mon_busy = 1'b0;
            end else if (mon_busy) begin
               if (!nrd0) mon_rd_lo++;
               if (!nwr0) mon_wr_lo++;
               if (!nrd0 && !nwr0) mon_both++;
               if ((!nrd0 || !nwr0) && mon_first < 0) mon_first = cyc - mon_acc;
               if (!ncs0) mon_ncs_lo++;
               if (bus0.req_ready) mon_rdy++;
            end
            if (bus0.req_valid && bus0.req_ready) begin
               mon_busy   = 1'b1;
               mon_acc    = cyc;
               mon_rd_lo  = 0;
               mon_wr_lo  = 0;
               mon_first  = -1;
               mon_ncs_lo = 0;
               mon_rdy    = 0;
               mon_both   = 0;
               acc_log.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cnt_nrd, cnt_ncs, cnt_oe, cnt_nwr, lat;
      bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready",     32'(bus0.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
      check("rst_rdata",     32'(bus0.rsp_rdata), 32'd0);
      check("rst_cart_a",    32'(a0), 32'd0);
      check("rst_d_out",     32'(dout0), 32'd0);
      check("rst_d_oe",      32'(doe0), 32'd0);
      check("rst_strobes",   32'({nrd0, nwr0, ncs0}), 32'b111);
      check("rst_ready_d1",  32'(bus1.req_ready), 32'd1);
`ifdef MBC1_SHADOW_EN
      check("rst_sh_dut1", 32'({sh_ram_en1, sh_rom1, sh_ram1, sh_mode1}), 32'({1'b0, 7'h01, 2'd0, 1'b0}));
`endif
      @(posedge clk); #1;

      // MBC1 ROM bank write of 0: outside RAM window, 4-cycle nWR.
      send(1'b1, 16'h2000, 8'h00, 1'b0);
      drain();
`ifdef MBC1_SHADOW_EN
      check("sh_rom_bank_zero", 32'(sh_rom0), 32'h01);
`endif

      // RAM-window read.
      d_in = 8'h5A;
      send(1'b0, 16'hA123, 8'h00, 1'b0);
      drain();
      check("cart_a_kept", 32'(a0), 32'hA123);

      // Back-to-back writes with req_valid held; rsp_rdata must keep 0x5A.
      send(1'b1, 16'hA000, 8'h11, 1'b1);
      send(1'b1, 16'hB000, 8'h22, 1'b0);
      drain();
      n = acc_log.size();
      check("b2b_period", acc_log[n-1] - acc_log[n-2], 8);

      // Reset in the middle of a write strobe drops the transaction.
      send(1'b1, 16'h2000, 8'h05, 1'b0);
      n = 0;
      while (nwr0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("nwr_seen", 32'(nwr0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("rstmid_nwr",   32'(nwr0), 32'd1);
      check("rstmid_d_oe",  32'(doe0), 32'd0);
      check("rstmid_ready", 32'(bus0.req_ready), 32'd1);
      check("rstmid_rsp",   32'(bus0.rsp_valid), 32'd0);
      check("rstmid_ncs_a", 32'({ncs0, a0}), 32'({1'b1, 16'h0000}));
      @(posedge clk); #1;
      rst = 1'b0;
      model_rdata = 8'h00;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus0.rsp_valid) n++;
      end
      check("rstmid_no_rsp", n, 0);
      @(posedge clk); #1;

`ifdef MBC1_SHADOW_EN
      send(1'b1, 16'h0000, 8'h1A, 1'b0);
      send(1'b1, 16'h4000, 8'h03, 1'b0);
      send(1'b1, 16'h2000, 8'h1F, 1'b0);
      send(1'b1, 16'h6000, 8'h01, 1'b0);
      drain();
      check("sh_ram_en_on", 32'(sh_ram_en0), 32'd1);
      check("sh_rom_bank",  32'(sh_rom0), 32'h7F);
      check("sh_ram_bank",  32'(sh_ram0), 32'd3);
      check("sh_mode",      32'(sh_mode0), 32'd1);
      send(1'b1, 16'h0000, 8'h00, 1'b0);
      drain();
      check("sh_ram_en_off", 32'(sh_ram_en0), 32'd0);
`endif

      // ROM-area read (nCS stays high), then a write that must not disturb rsp_rdata.
      d_in = 8'hC3;
      send(1'b0, 16'h4567, 8'h00, 1'b0);
      send(1'b1, 16'h0100, 8'h99, 1'b0);
      drain();

      // Minimum timing 1/1/1 on the second instance.
      d_in = 8'h3C;
      bus1.req_valid = 1'b1;
      bus1.req_write = 1'b0;
      bus1.req_addr  = 16'hA000;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      cnt_nrd = 0; cnt_ncs = 0; cnt_oe = 0; cnt_nwr = 0; lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus1.rsp_valid) begin
            lat = k;
            break;
         end
         if (!nrd1) cnt_nrd++;
         if (!nwr1) cnt_nwr++;
         if (!ncs1) cnt_ncs++;
         if (doe1)  cnt_oe++;
      end
      check("min_latency", lat, 4);
      check("min_nrd_low", cnt_nrd, 1);
      check("min_nwr_low", cnt_nwr, 0);
      check("min_ncs_low", cnt_ncs, 3);
      check("min_d_oe",    cnt_oe, 0);
      check("min_rdata",   32'(bus1.rsp_rdata), 32'h3C);
      check("min_cart_a",  32'({a1, dout1}), 32'({16'hA000, 8'h00}));
`ifdef MBC1_SHADOW_EN
      check("min_sh", 32'({sh_ram_en1, sh_rom1, sh_ram1, sh_mode1}), 32'({1'b0, 7'h01, 2'd0, 1'b0}));
`endif

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
